// File: rtl/hilo_muldiv_if.sv
// Pipeline-facing bundle of the HI/LO multiply/divide unit: request, operands,
// read hazard input, and the status/result outputs.
interface hilo_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             read_req;
  logic             busy;
  logic             done;
  logic             stall_req;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, rs_val, rt_val, read_req,
    input  busy, done, stall_req, hi, lo
  );

  modport slave (
    input  start, op, rs_val, rt_val, read_req,
    output busy, done, stall_req, hi, lo
  );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers: shift-add multiply,
// restoring divide on magnitudes, sign fix-up and HI/LO write in a final cycle.
module hilo_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         reset,
  hilo_muldiv_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_e;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } op_e;

  localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   rs_q, rs_d;
  logic               fix_mul_q, fix_mul_d;
  logic               neg_lo_q, neg_lo_d;
  logic               neg_hi_q, neg_hi_d;
  logic               div_zero_q, div_zero_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  // Operand magnitudes, only treated as signed for MULT/DIV.
  logic             signed_op;
  logic             rs_neg, rt_neg;
  logic [WIDTH-1:0] rs_mag, rt_mag;

  assign signed_op = (bus.op == OP_MULT) || (bus.op == OP_DIV);
  assign rs_neg    = signed_op & bus.rs_val[WIDTH-1];
  assign rt_neg    = signed_op & bus.rt_val[WIDTH-1];
  assign rs_mag    = rs_neg ? -bus.rs_val : bus.rs_val;
  assign rt_mag    = rt_neg ? -bus.rt_val : bus.rt_val;

  // Multiply step: acc = {partial product, remaining multiplier bits}.
  logic [WIDTH:0] mul_sum;
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);

  // Divide step: acc = {remainder, dividend bits shifting into quotient}.
  logic [WIDTH:0] div_shift, div_diff;
  assign div_shift = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_diff  = div_shift - {1'b0, opnd_q};

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  assign prod_fix = neg_lo_q ? -acc_q : acc_q;
  assign quo_fix  = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves one unassigned (no latches).
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    rs_d       = rs_q;
    fix_mul_d  = fix_mul_q;
    neg_lo_d   = neg_lo_q;
    neg_hi_d   = neg_hi_q;
    div_zero_d = div_zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          case (bus.op)
            OP_MULT, OP_MULTU: begin
              state_d   = S_MUL;
              cnt_d     = '0;
              opnd_d    = rs_mag;
              acc_d     = {{WIDTH{1'b0}}, rt_mag};
              fix_mul_d = 1'b1;
              neg_lo_d  = rs_neg ^ rt_neg;
              neg_hi_d  = rs_neg ^ rt_neg;
            end
            OP_DIV, OP_DIVU: begin
              state_d    = S_DIV;
              cnt_d      = '0;
              opnd_d     = rt_mag;
              acc_d      = {{WIDTH{1'b0}}, rs_mag};
              rs_d       = bus.rs_val;
              fix_mul_d  = 1'b0;
              neg_lo_d   = rs_neg ^ rt_neg;
              neg_hi_d   = rs_neg;
              div_zero_d = (bus.rt_val == '0);
            end
            OP_MTHI: hi_d = bus.rs_val;
            OP_MTLO: lo_d = bus.rs_val;
            default: ;
          endcase
        end
      end

      S_MUL: begin
        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) state_d = S_FIX;
      end

      S_DIV: begin
        if (!div_diff[WIDTH]) acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        else                  acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) state_d = S_FIX;
      end

      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (fix_mul_q) begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else if (div_zero_q) begin
          hi_d = rs_q;
          lo_d = '1;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      // NOTE: the datapath is cleared too, so an aborted operation leaves nothing behind.
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      rs_q       <= '0;
      fix_mul_q  <= 1'b0;
      neg_lo_q   <= 1'b0;
      neg_hi_q   <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      rs_q       <= rs_d;
      fix_mul_q  <= fix_mul_d;
      neg_lo_q   <= neg_lo_d;
      neg_hi_q   <= neg_hi_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
    end
  end

  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = done_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.stall_req = bus.busy & (bus.read_req | bus.start);

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit: expected HI/LO pushed at issue time,
// popped and compared whenever done pulses; latency, hazard and reset cases checked inline.
module tb_hilo_muldiv_unit;

  localparam int W = 32;
  localparam logic [2:0] MULT = 3'b000, MULTU = 3'b001, DIV = 3'b010, DIVU = 3'b011,
                         MTHI = 3'b100, MTLO = 3'b101, BADOP = 3'b111;

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  exp_t sb_q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  hilo_muldiv_if #(.WIDTH(W)) bus ();

  hilo_muldiv_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Independent reference for the four arithmetic ops, returns {hi, lo}.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] ua, ub;
    int          q, r;
    model = '0;
    case (op)
      MULT: begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        model = 64'(sa * sb);
      end
      MULTU: begin
        ua = {32'b0, a};
        ub = {32'b0, b};
        model = ua * ub;
      end
      DIV: begin
        if (b == 32'h0) model = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) model = {32'h0, 32'h8000_0000};
        else begin
          q = $signed(a) / $signed(b);
          r = $signed(a) % $signed(b);
          model = {r, q};
        end
      end
      DIVU: begin
        if (b == 32'h0) model = {a, 32'hFFFF_FFFF};
        else model = {a % b, a / b};
      end
      default: model = '0;
    endcase
  endfunction

  // Scoreboard consumer: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (bus.done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 64'(bus.done), 64'(0));
      end else begin
        e = sb_q.pop_front();
        check({e.tag, "_hi"}, 64'(bus.hi), 64'(e.hi));
        check({e.tag, "_lo"}, 64'(bus.lo), 64'(e.lo));
      end
    end
  end

  // Drive a start for one edge (call near a negedge); operands are scrambled afterwards.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input string tag, input logic [31:0] ehi, input logic [31:0] elo,
                       input bit push);
    exp_t e;
    bus.start  = 1'b1;
    bus.op     = op;
    bus.rs_val = a;
    bus.rt_val = b;
    if (push) begin
      e.tag = tag;
      e.hi  = ehi;
      e.lo  = elo;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    bus.op     = 3'($urandom);
    bus.rs_val = $urandom;
    bus.rt_val = $urandom;
  endtask

  // Returns at the negedge where done is seen; cycles counted from the start edge.
  task automatic wait_done(input string tag, output int cyc, output int nbusy);
    cyc   = 0;
    nbusy = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      cyc++;
      if (bus.busy) nbusy++;
      if (bus.done) return;
    end
    check({tag, "_timeout"}, 64'(0), 64'(1));
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string tag, input logic [31:0] ehi, input logic [31:0] elo);
    int cyc, nb;
    @(negedge clk);
    issue(op, a, b, tag, ehi, elo, 1'b1);
    wait_done(tag, cyc, nb);
    check({tag, "_latency"}, 64'(cyc), 64'(34));
  endtask

  initial begin
    int          cyc, nb;
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    logic [63:0] m;

    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.op       = 3'b000;
    bus.rs_val   = '0;
    bus.rt_val   = '0;
    bus.read_req = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_done", 64'(bus.done), 64'(0));
    check("rst_hilo", {bus.hi, bus.lo}, 64'(0));

    // Full-range unsigned product with latency and busy window.
    @(negedge clk);
    issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max", 32'hFFFF_FFFE, 32'h0000_0001, 1'b1);
    wait_done("multu_max", cyc, nb);
    check("multu_max_latency", 64'(cyc), 64'(34));
    check("multu_max_busy", 64'(nb), 64'(33));

    run_op(MULT,  32'hFFFF_FFFD, 32'h7, "mult_neg",   32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op(MULTU, 32'hFFFF_FFFD, 32'h7, "multu_same", 32'h0000_0006, 32'hFFFF_FFEB);
    run_op(DIV,   32'hFFFF_FFF9, 32'h2, "div_neg",    32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op(DIVU,  32'h7,         32'h0, "divu_zero",  32'h0000_0007, 32'hFFFF_FFFF);
    run_op(DIV,   32'hFFFF_FFF9, 32'h0, "div_zero",   32'hFFFF_FFF9, 32'hFFFF_FFFF);
    run_op(DIVU,  32'd100,       32'd7, "divu_small", 32'd2,         32'd14);
    run_op(DIV,   32'd7,  32'hFFFF_FFFE, "div_negrt", 32'd1,         32'hFFFF_FFFD);

    // Overflow case, then a new start in the done cycle.
    @(negedge clk);
    issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 32'h0, 32'h8000_0000, 1'b1);
    wait_done("div_ovf", cyc, nb);
    issue(MULTU, 32'h1234_5678, 32'h10, "b2b", 32'h1, 32'h2345_6780, 1'b1);
    wait_done("b2b", cyc, nb);
    check("b2b_latency", 64'(cyc), 64'(34));

    // Single-cycle moves and an unknown op.
    @(negedge clk);
    issue(MTHI, 32'h1234, 32'h0, "", 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    check("mthi_hilo", {bus.hi, bus.lo}, {32'h1234, 32'h2345_6780});
    check("mthi_status", {62'b0, bus.busy, bus.done}, 64'(0));
    issue(MTLO, 32'hABCD, 32'h0, "", 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    check("mtlo_hilo", {bus.hi, bus.lo}, {32'h1234, 32'hABCD});
    issue(BADOP, 32'h5555, 32'h6666, "", 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    check("badop_status", {62'b0, bus.busy, bus.done}, 64'(0));
    check("badop_hilo", {bus.hi, bus.lo}, {32'h1234, 32'hABCD});

    bus.read_req = 1'b1;
    #1 check("stall_idle", 64'(bus.stall_req), 64'(0));
    bus.read_req = 1'b0;

    // MFHI/MFLO hazard while a divide runs.
    @(negedge clk);
    issue(DIVU, 32'd1000, 32'd10, "divu_rd", 32'd0, 32'd100, 1'b1);
    repeat (3) @(negedge clk);
    bus.read_req = 1'b1;
    #1 check("stall_read", 64'(bus.stall_req), 64'(1));
    bus.read_req = 1'b0;
    wait_done("divu_rd", cyc, nb);

    // A start during a multiply must be ignored.
    @(negedge clk);
    issue(MULT, 32'd5, 32'hFFFF_FFFA, "mult_ign", 32'hFFFF_FFFF, 32'hFFFF_FFE2, 1'b1);
    repeat (5) @(negedge clk);
    bus.start  = 1'b1;
    bus.op     = DIVU;
    bus.rs_val = 32'd100;
    bus.rt_val = 32'd3;
    #1 check("stall_start", 64'(bus.stall_req), 64'(1));
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_done("mult_ign", cyc, nb);

    // Random operations against the reference model.
    for (int i = 0; i < 10; i++) begin
      rop = 3'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      m   = model(rop, ra, rb);
      run_op(rop, ra, rb, $sformatf("rnd%0d", i), m[63:32], m[31:0]);
    end

    // Abort a divide partway; no done pulse may follow.
    @(negedge clk);
    issue(DIV, 32'd12345, 32'd7, "", 32'h0, 32'h0, 1'b0);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort_busy", 64'(bus.busy), 64'(0));
    check("abort_hilo", {bus.hi, bus.lo}, 64'(0));
    nb = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.done) nb++;
    end
    check("abort_no_done", 64'(nb), 64'(0));
    run_op(MULTU, 32'd2, 32'd3, "post_abort", 32'd0, 32'd6);

    repeat (3) @(negedge clk);
    check("sb_empty", 64'(sb_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
